demux64_capture: RTL and testbench
==================================

DEMUX64_CAPTURE -- requirements
Module: demux64_capture

Interface
REQ-001 Parameters: none; word width fixed at 64, select width fixed at 6.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 bit_in  input  1  serial data bit to be steered into the word.
REQ-005 bit_valid  input  1  bit_in is valid this cycle.
REQ-006 bit_ready  output  1  block accepts a bit this cycle; a bit is accepted when bit_valid && bit_ready.
REQ-007 use_sel  input  1  1 = write at select; 0 = write at the internal auto pointer.
REQ-008 select  input  6  target bit index when use_sel=1; ignored otherwise.
REQ-009 flush  input  1  request emission of a partially filled word.
REQ-010 word_out  output  64  assembled word; unwritten positions read 0.
REQ-011 word_mask  output  64  bit i = 1 if position i was written since the last emission.
REQ-012 word_valid  output  1  word_out/word_mask are valid.
REQ-013 word_ready  input  1  consumer accepts the word; handshake when word_valid && word_ready.

Function
REQ-014 The block SHALL implement two states: FILL (bit_ready=1, word_valid=0) and HOLD (bit_ready=0, word_valid=1).
REQ-015 In FILL, an accepted bit SHALL write word_reg[idx]=bit_in and set mask[idx]=1, where idx=select if use_sel=1, else the auto pointer.
REQ-016 An accepted bit with use_sel=0 SHALL advance the 6-bit auto pointer by 1, wrapping 63->0; a bit with use_sel=1 SHALL leave the pointer unchanged.
REQ-017 A write to an already-written position SHALL overwrite the data bit; the mask bit stays 1.
REQ-018 FILL->HOLD SHALL occur on the edge where the mask becomes (or already is) all ones, so word_valid is high in the cycle after the completing bit is accepted (1-cycle latency).
REQ-019 FILL->HOLD SHALL also occur on an edge where flush=1 and the mask after that edge's write is nonzero.
REQ-020 flush with a bit accepted in the same cycle: the bit SHALL be written first and included in the emitted word.
REQ-021 flush while the resulting mask is zero SHALL be ignored (remain in FILL, no emission).
REQ-022 In HOLD, word_out and word_mask SHALL remain stable until the handshake; bit_valid, use_sel, select, bit_in and flush SHALL be ignored.
REQ-023 On the HOLD handshake edge, the block SHALL clear word_reg, mask and auto pointer to 0 and return to FILL; bit_ready is 1 in the following cycle (one bubble cycle, no bit accepted on the handshake edge).
REQ-024 word_valid SHALL never deassert in HOLD without a handshake.
REQ-025 The 64th distinct position written via use_sel=1 SHALL complete the word identically to auto mode; mixing modes within one word SHALL be permitted.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL enter FILL with word_reg=0, mask=0, pointer=0; outputs the next cycle: word_out=0, word_mask=0, word_valid=0, bit_ready=1.
REQ-027 Reset SHALL take priority over every other input, including during HOLD and on a handshake or flush edge; a held word is discarded.
REQ-028 bit_ready SHALL be 1 during reset cycles, but no bit SHALL be written while rst_n=0.

Verification
REQ-029 Auto fill: after reset, 64 consecutive bits with use_sel=0 of 0xA5A5A5A5A5A5A5A5, LSB first -> word_valid=1 on the next cycle, word_out=0xA5A5A5A5A5A5A5A5, word_mask=all ones.
REQ-030 Backpressure: full word held with word_ready=0 for 10 cycles while bit_valid=1 -> word_out is stable, bit_ready=0, and no bits are lost or written; word_ready=1 -> FILL with all state 0 one cycle later.
REQ-031 Explicit select plus flush: use_sel=1 writes 1 at index 63, then 1 at index 5, then flush -> word_out=0x8000000000000020, word_mask=0x8000000000000020.
REQ-032 Overwrite and same-cycle flush: write 1 then 0 at select=7, then auto bit 1 at pointer 0 with flush=1 in the same cycle -> word_out=0x0000000000000001, word_mask=0x0000000000000081.
REQ-033 Empty flush: flush=1 with mask=0 -> word_valid stays 0 and the state remains FILL.
REQ-034 Reset mid-HOLD: rst_n=0 for one cycle while word_valid=1 -> word_valid=0, word_mask=0, bit_ready=1 on the next cycle.

Source files
------------

// File: rtl/demux64_capture.sv
// Serial-to-parallel capture: steers single bits into a 64-bit word by select or auto pointer,
// then holds the assembled word (with a written-position mask) until the consumer takes it.
module demux64_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        use_sel,
  input  logic [5:0]  select,
  input  logic        flush,
  output logic [63:0] word_out,
  output logic [63:0] word_mask,
  output logic        word_valid,
  input  logic        word_ready
);

  localparam int unsigned WordW = 64;
  localparam int unsigned SelW  = 6;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [WordW-1:0]  mask_q, mask_d;
  logic [SelW-1:0]   ptr_q, ptr_d;
  logic [SelW-1:0]   idx;
  logic              valid_q, ready_q;

  // Next-state: write-then-decide, so a same-cycle flush sees the bit just written.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    idx     = use_sel ? select : ptr_q;
    case (state_q)
      ST_FILL: begin
        if (bit_valid) begin
          word_d[idx] = bit_in;
          mask_d[idx] = 1'b1;
          if (!use_sel) ptr_d = ptr_q + SelW'(1);
        end
        if ((&mask_d) || (flush && (|mask_d))) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (word_ready) begin
          word_d  = '0;
          mask_d  = '0;
          ptr_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      word_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      valid_q <= (state_d == ST_HOLD);
      ready_q <= (state_d == ST_FILL);
    end
  end

  // Ready is forced high while reset is asserted; no write can land since reset wins.
  assign bit_ready  = ready_q | ~rst_n;
  assign word_valid = valid_q;
  assign word_out   = word_q;
  assign word_mask  = mask_q;

endmodule

// File: tb/tb_demux64_capture.sv
// Scoreboard bench for demux64_capture: expected words are queued at stimulus time
// and compared when the consumer handshake is seen.
module tb_demux64_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        use_sel;
  logic [5:0]  select;
  logic        flush;
  logic [63:0] word_out;
  logic [63:0] word_mask;
  logic        word_valid;
  logic        word_ready;

  typedef struct packed {
    logic [63:0] w;
    logic [63:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;

  demux64_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .use_sel    (use_sel),
    .select     (select),
    .flush      (flush),
    .word_out   (word_out),
    .word_mask  (word_mask),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit for one edge, then drop valid/flush.
  task automatic send(input logic v, input logic b, input logic us, input logic [5:0] s,
                      input logic f);
    bit_valid = v;
    bit_in    = b;
    use_sel   = us;
    select    = s;
    flush     = f;
    tick();
    bit_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Handshake edge follows this negedge; pop and compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_word", word_out, e.w);
        check("sb_mask", word_mask, e.m);
      end
    end
  end

  initial begin
    logic [63:0] mw;
    logic        b;
    int          perm[32];
    int          j, t;

    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; use_sel = 1'b0;
    select = '0; flush = 1'b0; word_ready = 1'b0;

    // Reset, with a bit offered that must not land
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    check("rst_ready", 64'(bit_ready), 64'd1);
    tick();
    bit_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_word", word_out, 64'd0);
    check("rst_mask", word_mask, 64'd0);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_ready_after", 64'(bit_ready), 64'd1);

    // Auto fill with A5 pattern, LSB first, consumer stalled
    for (int i = 0; i < 64; i++) begin
      if (i == 63) exp_q.push_back('{w: A5, m: ONES});
      send(1'b1, A5[i], 1'b0, 6'd0, 1'b0);
      if (i == 62) check("auto_not_early", 64'(word_valid), 64'd0);
    end
    check("auto_valid", 64'(word_valid), 64'd1);
    check("auto_word", word_out, A5);
    check("auto_mask", word_mask, ONES);

    // Backpressure: inputs must be ignored while holding
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      use_sel   = 1'($urandom);
      select    = 6'($urandom);
      flush     = 1'($urandom);
      tick();
      check("hold_word", word_out, A5);
      check("hold_mask", word_mask, ONES);
      check("hold_valid", 64'(word_valid), 64'd1);
      check("hold_ready", 64'(bit_ready), 64'd0);
    end
    bit_valid = 1'b0; flush = 1'b0; use_sel = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("release_valid", 64'(word_valid), 64'd0);
    check("release_ready", 64'(bit_ready), 64'd1);
    check("release_word", word_out, 64'd0);
    check("release_mask", word_mask, 64'd0);

    // Explicit select then flush
    send(1'b1, 1'b1, 1'b1, 6'd63, 1'b0);
    send(1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
    check("sel_no_early", 64'(word_valid), 64'd0);
    exp_q.push_back('{w: 64'h8000_0000_0000_0020, m: 64'h8000_0000_0000_0020});
    send(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    check("sel_flush_valid", 64'(word_valid), 64'd1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Overwrite, then auto bit at pointer 0 with same-cycle flush
    send(1'b1, 1'b1, 1'b1, 6'd7, 1'b0);
    send(1'b1, 1'b0, 1'b1, 6'd7, 1'b0);
    exp_q.push_back('{w: 64'h1, m: 64'h81});
    send(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    check("ovr_valid", 64'(word_valid), 64'd1);
    check("ovr_word", word_out, 64'h1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Empty flush is ignored
    send(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    send(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    check("eflush_valid", 64'(word_valid), 64'd0);
    check("eflush_ready", 64'(bit_ready), 64'd1);

    // Mixed modes: 32 auto bits, then the upper 32 by shuffled select
    mw = '0;
    for (int i = 0; i < 32; i++) begin
      b = 1'($urandom);
      mw[i] = b;
      send(1'b1, b, 1'b0, 6'd0, 1'b0);
    end
    for (int i = 0; i < 32; i++) perm[i] = 32 + i;
    for (int i = 31; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 32; i++) begin
      b = 1'($urandom);
      mw[perm[i]] = b;
      if (i == 31) exp_q.push_back('{w: mw, m: ONES});
      send(1'b1, b, 1'b1, 6'(perm[i]), 1'b0);
      if (i == 30) check("mix_not_early", 64'(word_valid), 64'd0);
    end
    check("mix_valid", 64'(word_valid), 64'd1);
    check("mix_ready", 64'(bit_ready), 64'd0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Reset while holding discards the word
    send(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    check("rh_valid", 64'(word_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rh_ready_in_reset", 64'(bit_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    check("rh_valid_after", 64'(word_valid), 64'd0);
    check("rh_mask_after", word_mask, 64'd0);
    check("rh_ready_after", 64'(bit_ready), 64'd1);

    // Pointer restarts at 0 after reset
    exp_q.push_back('{w: 64'h1, m: 64'h1});
    send(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
